paddle_position: RTL

//   Consumes the 10-bit rotary count from the paddle input stage and turns it into
//   an on-screen paddle Y position. Once per frame it computes the signed count

---
 rtl/paddle_position.sv | 107 ++++++++++
 1 files changed

// File: rtl/paddle_position.sv
// Paddle Y tracker: once per frame turns the encoder count delta into a limited,
// scaled move of paddle_y clamped to the playfield, plus a registered draw flag.
module paddle_position #(
  parameter int SCREEN_H   = 480,
  parameter int PADDLE_H   = 64,
  parameter int PADDLE_W   = 8,
  parameter int X_LEFT     = 16,
  parameter int STEP_SHIFT = 1,
  parameter int MAX_STEP   = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] move,
  input  logic       frame_tick,
  input  logic [9:0] hpos,
  input  logic [9:0] vpos,
  output logic [9:0] paddle_y,
  output logic       draw
);

  localparam int Y_MAX   = SCREEN_H - PADDLE_H;
  localparam int Y_RESET = (SCREEN_H - PADDLE_H) / 2;

  localparam logic signed [11:0] STEP_LIM = 12'(MAX_STEP);
  localparam logic signed [11:0] STEP_NEG = -12'(MAX_STEP);
  localparam logic signed [11:0] Y_MAX_S  = 12'(Y_MAX);
  localparam logic [9:0]         Y_MAX_U  = 10'(Y_MAX);
  localparam logic [9:0]         Y_RST_U  = 10'(Y_RESET);
  localparam logic [10:0]        X_LO     = 11'(X_LEFT);
  localparam logic [10:0]        X_HI     = 11'(X_LEFT + PADDLE_W);
  localparam logic [10:0]        P_H      = 11'(PADDLE_H);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELTA = 2'd1,
    APPLY = 2'd2
  } state_t;

  state_t             state, state_next;
  logic [9:0]         move_prev, move_prev_next;
  logic signed [11:0] delta, delta_next;
  logic [9:0]         paddle_y_next;
  logic               draw_next;
  logic [9:0]         raw_diff;
  logic signed [11:0] clamped;
  logic signed [11:0] y_sum;
  logic               in_x, in_y;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      move_prev <= '0;
      delta     <= '0;
      paddle_y  <= Y_RST_U;
      draw      <= 1'b0;
    end else begin
      state     <= state_next;
      move_prev <= move_prev_next;
      delta     <= delta_next;
      paddle_y  <= paddle_y_next;
      draw      <= draw_next;
    end
  end

  always_comb begin
    state_next     = state;
    move_prev_next = move_prev;
    delta_next     = delta;
    paddle_y_next  = paddle_y;
    // Modulo-1024 difference read as signed gives correct direction across wrap.
    raw_diff       = move - move_prev;
    clamped        = delta;
    y_sum          = $signed({2'b00, paddle_y}) + delta;
    case (state)
      IDLE: begin
        if (frame_tick) begin
          delta_next     = {{2{raw_diff[9]}}, raw_diff};
          move_prev_next = move;
          state_next     = DELTA;
        end
      end
      DELTA: begin
        if (delta > STEP_LIM)      clamped = STEP_LIM;
        else if (delta < STEP_NEG) clamped = STEP_NEG;
        else                       clamped = delta;
        delta_next = clamped <<< STEP_SHIFT;
        state_next = APPLY;
      end
      APPLY: begin
        if (y_sum < 12'sd0)        paddle_y_next = '0;
        else if (y_sum > Y_MAX_S)  paddle_y_next = Y_MAX_U;
        else                       paddle_y_next = y_sum[9:0];
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Compare against the live paddle_y; it only changes during blanking.
  always_comb begin
    in_x      = ({1'b0, hpos} >= X_LO) && ({1'b0, hpos} < X_HI);
    in_y      = ({1'b0, vpos} >= {1'b0, paddle_y}) &&
                ({1'b0, vpos} < ({1'b0, paddle_y} + P_H));
    draw_next = in_x && in_y;
  end

endmodule
